led_pulse_stretch: RTL and testbench

//  Human-visible output driver. Turns single-cycle event pulses into LED blinks

---
 rtl/led_pulse_stretch.sv | 121 ++++++++++++
 tb/tb_led_pulse_stretch.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/led_pulse_stretch.sv
// LED pulse stretcher: turns single-cycle events into fixed-length blinks with a
// forced off-gap. Events that arrive mid-blink are queued in a saturating counter.
module led_pulse_stretch #(
  parameter int ON_COUNT  = 2500000,
  parameter int OFF_COUNT = 2500000,
  parameter int PEND_MAX  = 15
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Pulse,
  input  logic       i_Enable,
  output logic       o_Led,
  output logic       o_Busy,
  output logic [3:0] o_Pending,
  output logic       o_Overflow
);

  localparam int MAX_COUNT = (ON_COUNT > OFF_COUNT) ? ON_COUNT : OFF_COUNT;
  localparam int CW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_COUNT - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_COUNT - 1);
  localparam logic [3:0]    PEND_LIM = 4'(PEND_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    pend, pend_nxt;
  logic          ovf, ovf_nxt;
  logic          queue_ev;
  logic          dequeue;
  logic          led_reg;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    ovf_nxt   = ovf;
    queue_ev  = 1'b0;
    dequeue   = 1'b0;
    if (!i_Enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      pend_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_Pulse) begin
            state_nxt = ON;
            cnt_nxt   = '0;
          end
        end
        ON: begin
          queue_ev = i_Pulse;
          if (cnt == ON_LAST) begin
            state_nxt = GAP;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        GAP: begin
          queue_ev = i_Pulse;
          if (cnt == OFF_LAST) begin
            cnt_nxt = '0;
            if (pend != '0) begin
              state_nxt = ON;
              dequeue   = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase

      // A new event coinciding with a dequeue takes the freed slot, so it can never overflow.
      if (dequeue && !queue_ev) begin
        pend_nxt = pend - 4'd1;
      end else if (queue_ev && !dequeue) begin
        if (pend == PEND_LIM) begin
          ovf_nxt = 1'b1;
        end else begin
          pend_nxt = pend + 4'd1;
        end
      end
    end
  end

  always_comb begin
    led_reg    = (state == ON);
    o_Led      = i_Enable ? led_reg : i_Pulse;
    o_Busy     = (state != IDLE);
    o_Pending  = pend;
    o_Overflow = ovf;
  end

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Scoreboard bench for led_pulse_stretch: a timeline model predicts each cycle's
// outputs into a queue; a monitor pops and compares after every clock edge.
module tb_led_pulse_stretch;

  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int PM  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse = 1'b0;
  logic       en = 1'b1;
  logic       led, busy, ovf;
  logic [3:0] pending;

  typedef struct {
    bit       led;
    bit       busy;
    int       pend;
    bit       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Timeline model: a blink is described by the edge index where it began.
  int   edge_no = 0;
  bit   m_act   = 0;
  int   m_bs    = 0;
  int   m_pend  = 0;
  bit   m_ovf   = 0;

  led_pulse_stretch #(.ON_COUNT(ON), .OFF_COUNT(OFF), .PEND_MAX(PM)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Pulse(pulse), .i_Enable(en),
    .o_Led(led), .o_Busy(busy), .o_Pending(pending), .o_Overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic step(input bit r, input bit e, input bit p);
    bit   q;
    exp_t x;
    @(negedge clk);
    rst = r; en = e; pulse = p;
    edge_no++;
    q = 0;
    if (r) begin
      m_act = 0; m_pend = 0; m_ovf = 0;
    end else if (!e) begin
      m_act = 0; m_pend = 0;
    end else if (m_act) begin
      if (edge_no == m_bs + ON + OFF) begin
        if (m_pend > 0) begin
          m_bs = edge_no;
          if (!p) m_pend--;
        end else begin
          m_act = 0;
          q = p;
        end
      end else begin
        q = p;
      end
    end else if (p) begin
      m_act = 1;
      m_bs  = edge_no;
    end
    if (q) begin
      if (m_pend == PM) m_ovf = 1;
      else m_pend++;
    end
    x.led  = e ? (m_act && (edge_no - m_bs) < ON) : p;
    x.busy = m_act;
    x.pend = m_pend;
    x.ovf  = m_ovf;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0);
  endtask

  task automatic cmp(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        cmp("o_Led", int'(led), int'(x.led));
        cmp("o_Busy", int'(busy), int'(x.busy));
        cmp("o_Pending", int'(pending), x.pend);
        cmp("o_Overflow", int'(ovf), int'(x.ovf));
      end
    end
  end

  initial begin : stimulus
    // Reset, then quiet line
    step(1, 1, 0); step(1, 1, 0);
    idle(20);
    // Single blink
    step(0, 1, 1); idle(12);
    // Three events, two queued
    step(0, 1, 1); idle(1); step(0, 1, 1); step(0, 1, 1); idle(25);
    // Saturation and sticky overflow
    for (int i = 0; i < 5; i++) step(0, 1, 1);
    idle(35);
    step(1, 1, 0);
    // One queued event plus a pulse on the last gap cycle
    step(0, 1, 1); step(0, 1, 1); idle(5); step(0, 1, 1); idle(25);
    // Reset mid-blink, then bypass mode
    step(0, 1, 1); step(0, 1, 0); step(1, 1, 0);
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
    idle(5);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, e, p;
      r = ($urandom_range(0, 399) == 0);
      e = ($urandom_range(0, 49) != 0);
      p = ($urandom_range(0, 99) < 30);
      step(r, e, p);
    end
    idle(3);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
